// File: rtl/operand_entry.sv
// Keypad operand entry for a two-operand calculator: builds signed operands A/B
// digit by digit, latches the operator and hands off to an arithmetic unit.
module operand_entry (
    input  logic        clk,
    input  logic        RST,
    input  logic        read_input,
    input  logic [3:0]  keypad_input,
    input  logic [2:0]  operator_input,
    input  logic        equal_input,
    output logic        key_read,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic [2:0]  op_code,
    output logic        calc_start,
    input  logic        calc_done,
    output logic [15:0] display_value,
    output logic        entry_err
);

    typedef enum logic [1:0] {
        ENTER_A     = 2'd0,
        ENTER_B     = 2'd1,
        WAIT_CALC   = 2'd2,
        SHOW_RESULT = 2'd3
    } state_t;

    localparam logic [2:0] OP_MINUS = 3'b001;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        key_read_q, key_read_d;
    logic        calc_start_q, calc_start_d;
    logic [14:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic        seen_a_q, seen_a_d, seen_b_q, seen_b_d;
    logic [2:0]  op_q, op_d;
    logic        err_q, err_d;

    logic        key_present, consume, is_arith, digit_ok, cur_seen;
    logic [14:0] cur_mag;
    logic [19:0] mag_new;

    assign key_present = read_input | (operator_input != 3'b000) | equal_input;
    assign is_arith    = (operator_input == 3'b010) || (operator_input == 3'b011) ||
                         (operator_input == 3'b100);
    // Keys are never taken while the arithmetic unit is busy.
    assign consume     = key_present & armed_q & (state_q != WAIT_CALC);

    assign cur_mag  = (state_q == ENTER_B) ? mag_b_q  : mag_a_q;
    assign cur_seen = (state_q == ENTER_B) ? seen_b_q : seen_a_q;
    assign mag_new  = 20'(cur_mag) * 20'd10 + 20'(keypad_input);
    assign digit_ok = (mag_new <= 20'd32767);

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        key_read_d   = 1'b0;
        calc_start_d = 1'b0;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        seen_a_d     = seen_a_q;
        seen_b_d     = seen_b_q;
        op_d         = op_q;
        err_d        = err_q;

        if (!key_present)
            armed_d = 1'b1;

        if (consume) begin
            armed_d    = 1'b0;
            key_read_d = 1'b1;
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (equal_input) begin
                        if (state_q == ENTER_B) begin
                            calc_start_d = 1'b1;
                            state_d      = WAIT_CALC;
                        end
                    end else if (operator_input != 3'b000) begin
                        if (operator_input == OP_MINUS) begin
                            if (!cur_seen && cur_mag == 15'd0) begin
                                if (state_q == ENTER_B) sign_b_d = ~sign_b_q;
                                else                    sign_a_d = ~sign_a_q;
                            end
                        end else if (is_arith) begin
                            op_d = operator_input;
                            if (state_q == ENTER_A) begin
                                mag_b_d  = '0;
                                sign_b_d = 1'b0;
                                seen_b_d = 1'b0;
                                state_d  = ENTER_B;
                            end
                        end
                    end else if (digit_ok) begin
                        if (state_q == ENTER_B) begin
                            mag_b_d  = mag_new[14:0];
                            seen_b_d = 1'b1;
                        end else begin
                            mag_a_d  = mag_new[14:0];
                            seen_a_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SHOW_RESULT: begin
                    // Any digit/operator starts a fresh calculation.
                    if (!equal_input) begin
                        mag_a_d  = '0;
                        sign_a_d = 1'b0;
                        seen_a_d = 1'b0;
                        mag_b_d  = '0;
                        sign_b_d = 1'b0;
                        seen_b_d = 1'b0;
                        op_d     = 3'b000;
                        err_d    = 1'b0;
                        if (operator_input != 3'b000) begin
                            if (operator_input == OP_MINUS) begin
                                sign_a_d = 1'b1;
                                state_d  = ENTER_A;
                            end else if (is_arith) begin
                                op_d    = operator_input;
                                state_d = ENTER_B;
                            end else begin
                                state_d = ENTER_A;
                            end
                        end else begin
                            mag_a_d  = 15'(keypad_input);
                            seen_a_d = 1'b1;
                            state_d  = ENTER_A;
                        end
                    end
                end
                default: ;
            endcase
        end else if (state_q == WAIT_CALC && calc_done) begin
            state_d = SHOW_RESULT;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= ENTER_A;
            armed_q      <= 1'b1;
            key_read_q   <= 1'b0;
            calc_start_q <= 1'b0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            seen_a_q     <= 1'b0;
            seen_b_q     <= 1'b0;
            op_q         <= 3'b000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            key_read_q   <= key_read_d;
            calc_start_q <= calc_start_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            seen_a_q     <= seen_a_d;
            seen_b_q     <= seen_b_d;
            op_q         <= op_d;
            err_q        <= err_d;
        end
    end

    assign operand_a     = sign_a_q ? -{1'b0, mag_a_q} : {1'b0, mag_a_q};
    assign operand_b     = sign_b_q ? -{1'b0, mag_b_q} : {1'b0, mag_b_q};
    // B stays on display through the calculation; the result is shown elsewhere.
    assign display_value = (state_q == ENTER_A) ? operand_a : operand_b;
    assign key_read      = key_read_q;
    assign calc_start    = calc_start_q;
    assign op_code       = op_q;
    assign entry_err     = err_q;

endmodule
